// File: rtl/rom_reader.sv
// rom_reader: streams LEN_I bytes from a registered-output ROM, starting at BASE_I, through a 2-entry output buffer
// Ports: CLK_I clock; RST_N_I asynchronous active-low reset; START_I/BASE_I/LEN_I transfer request;
//   BUSY_O high while reading or draining, DONE_O one-cycle end pulse; ROM_ADDR_O/ROM_EN_O/ROM_Q_I ROM read port;
//   DAT_O/VLD_O/RDY_I output stream; CSUM_O running byte sum, present only when ROM_READER_CSUM_EN is defined.
module rom_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              START_I,
  input  logic [ADDR_W-1:0] BASE_I,
  input  logic [ADDR_W:0]   LEN_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [ADDR_W-1:0] ROM_ADDR_O,
  output logic              ROM_EN_O,
  input  logic [DATA_W-1:0] ROM_Q_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              VLD_O,
  input  logic              RDY_I
`ifdef ROM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0] CSUM_O
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] nxt_addr, last_addr;
  logic [ADDR_W:0] left;
  logic [DATA_W-1:0] buf0, buf1;
  logic [1:0] occ, occ_rem, occ_nxt;
  logic in_flight, pop, issue, done;
  always_comb begin
    pop = VLD_O & RDY_I;
    occ_rem = occ - {1'b0, pop};
    occ_nxt = occ_rem + {1'b0, in_flight};
    // the pop of this cycle frees a slot in time for a read issued now, which keeps 1 byte/cycle with only 2 entries
    issue = (state == RUN) && ({1'b0, occ} + {2'b0, in_flight} < 3'd2 + {2'b0, pop});
  end
  assign BUSY_O = state != IDLE;
  assign DONE_O = done;
  assign VLD_O = occ != 2'd0;
  assign DAT_O = buf0;
  assign ROM_EN_O = issue;
  assign ROM_ADDR_O = issue ? nxt_addr : last_addr;
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= IDLE;
      nxt_addr <= '0;
      last_addr <= '0;
      left <= '0;
      buf0 <= '0;
      buf1 <= '0;
      occ <= 2'd0;
      in_flight <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      in_flight <= issue;
      occ <= occ_nxt;
      if (pop) buf0 <= buf1;
      // returning ROM data lands behind whatever survives this cycle's pop
      if (in_flight && occ_rem == 2'd0) buf0 <= ROM_Q_I;
      if (in_flight && occ_rem != 2'd0) buf1 <= ROM_Q_I;
      if (issue) begin
        last_addr <= nxt_addr;
        nxt_addr <= nxt_addr + ADDR_W'(1);
        left <= left - (ADDR_W+1)'(1);
      end
      if (state == IDLE && START_I) begin
        nxt_addr <= BASE_I;
        left <= LEN_I;
        done <= LEN_I == '0;
        state <= LEN_I == '0 ? IDLE : RUN;
      end
      if (state == RUN && issue && left == (ADDR_W+1)'(1)) state <= DRAIN;
      if (state == DRAIN && occ_nxt == 2'd0) begin
        state <= IDLE;
        done <= 1'b1;
      end
    end
  end
`ifdef ROM_READER_CSUM_EN
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) CSUM_O <= '0;
    else if (state == IDLE && START_I) CSUM_O <= '0;
    else if (pop) CSUM_O <= CSUM_O + DAT_O;
  end
`endif
endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: randomized self-checking bench for rom_reader against a byte-sequence reference model
module tb_rom_reader;
  localparam int AW = 14;
  localparam int DW = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, rdy = 1'b1;
  logic [AW-1:0] base = '0, rom_addr;
  logic [AW:0] len = '0;
  logic busy, done, rom_en, vld;
  logic [DW-1:0] rom_q = '0, dat;
  logic [3:0] pat = 4'b1001;
`ifdef ROM_READER_CSUM_EN
  logic [DW-1:0] csum;
`endif
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  int first_iss = -1, first_vld = -1, last_vld = -1, done_cnt = 0, outst = 0;
  int viol = 0, stall_viol = 0, en_cnt = 0, vld_cnt = 0, exp_csum = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  int got[$], iss[$], exp_b[$], exp_a[$];

  rom_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .START_I(start), .BASE_I(base), .LEN_I(len),
    .BUSY_O(busy), .DONE_O(done), .ROM_ADDR_O(rom_addr), .ROM_EN_O(rom_en), .ROM_Q_I(rom_q),
    .DAT_O(dat), .VLD_O(vld), .RDY_I(rdy)
`ifdef ROM_READER_CSUM_EN
    , .CSUM_O(csum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_q <= rom_addr[DW-1:0];
  end

  // outst = bytes issued but not yet handed downstream (buffered or in flight)
  always @(negedge clk) begin
    if (rom_en) begin
      iss.push_back(int'(rom_addr));
      en_cnt++;
      if (first_iss < 0) first_iss = cyc - t0;
      if (outst - int'(vld && rdy) >= 2) viol++;
    end
    if (vld) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc - t0;
      last_vld = cyc - t0;
    end
    if (vld && rdy) got.push_back(int'(dat));
    if (prev_stall && (vld !== 1'b1 || dat !== prev_dat)) stall_viol++;
    prev_stall = vld && !rdy;
    prev_dat = dat;
    outst += int'(rom_en) - int'(vld && rdy);
    if (done && cyc != t0) done_cnt++;
  end

  function automatic int diff(input int a[$], input int b[$]);
    if (a.size() != b.size()) return a.size() < b.size() ? a.size() : b.size();
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  task automatic build_exp(input int b, input int l);
    exp_b.delete();
    exp_a.delete();
    exp_csum = 0;
    for (int i = 0; i < l; i++) begin
      exp_a.push_back((b + i) % (1 << AW));
      exp_b.push_back((b + i) % 256);
      exp_csum = (exp_csum + (b + i)) % 256;
    end
  endtask

  // called at #1 after a rising edge; that cycle becomes cycle 0 of the transfer
  task automatic start_xfer(input int b, input int l);
    got.delete();
    iss.delete();
    first_iss = -1;
    first_vld = -1;
    last_vld = -1;
    done_cnt = 0;
    outst = 0;
    viol = 0;
    stall_viol = 0;
    en_cnt = 0;
    vld_cnt = 0;
    prev_stall = 1'b0;
    start = 1'b1;
    base = AW'(b);
    len = (AW+1)'(l);
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: random ready and scrambled BASE/LEN
  task automatic wait_done(input int mode, output int rel);
    rel = -1;
    for (int k = 1; k < 400; k++) begin
      if (done) begin
        rel = k;
        return;
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[k % 4] : ($urandom_range(0, 3) != 0);
      if (mode == 2) begin
        base = AW'($urandom);
        len = (AW+1)'($urandom);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, rom_en, rom_addr, vld, dat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%h vld=%b dat=%h, want all 0", busy, done, rom_en, rom_addr, vld, dat);
    end
`ifdef ROM_READER_CSUM_EN
    total++;
    if (csum !== '0) begin
      bad++;
      $display("FAIL reset_csum: got %h want 00", csum);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || vld !== 1'b0 || rom_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b vld=%b en=%b want 0 0 0", busy, vld, rom_en);
    end
  endtask

  task automatic test_basic;
    int rel;
    rdy = 1'b1;
    build_exp('h10, 4);
    start_xfer('h10, 4);
    wait_done(0, rel);
    total++;
    if (rel != 7) begin
      bad++;
      $display("FAIL basic_done_cycle: got %0d want 7", rel);
    end
    total++;
    if (diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL basic_bytes: first diff %0d, got %0d bytes want %0d", diff(got, exp_b), got.size(), exp_b.size());
    end
    total++;
    if (first_iss != 1 || first_vld != 3 || last_vld != 6) begin
      bad++;
      $display("FAIL basic_latency: got issue=%0d vld=%0d..%0d want 1 3..6", first_iss, first_vld, last_vld);
    end
    total++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_state: got busy=%b vld=%b want 0 0", busy, vld);
    end
`ifdef ROM_READER_CSUM_EN
    total++;
    if (csum !== DW'(exp_csum)) begin
      bad++;
      $display("FAIL basic_csum: got %h want %h", csum, exp_csum);
    end
`endif
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || done_cnt != 1) begin
      bad++;
      $display("FAIL basic_done_pulse: got done=%b count=%0d want 0 1", done, done_cnt);
    end
  endtask

  task automatic test_wrap;
    int rel;
    rdy = 1'b1;
    build_exp('h3FFE, 4);
    start_xfer('h3FFE, 4);
    wait_done(0, rel);
    total++;
    if (rel < 0 || diff(iss, exp_a) != -1) begin
      bad++;
      $display("FAIL wrap_addr: rel=%0d first diff %0d, got %0d issues want %0d", rel, diff(iss, exp_a), iss.size(), exp_a.size());
    end
    total++;
    if (diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL wrap_bytes: first diff %0d, got %0d bytes want %0d", diff(got, exp_b), got.size(), exp_b.size());
    end
  endtask

  task automatic test_stall;
    int rel;
    build_exp(0, 8);
    start_xfer(0, 8);
    wait_done(1, rel);
    total++;
    if (rel < 0 || diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL stall_bytes: rel=%0d first diff %0d, got %0d bytes want %0d", rel, diff(got, exp_b), got.size(), exp_b.size());
    end
    total++;
    if (stall_viol != 0 || viol != 0) begin
      bad++;
      $display("FAIL stall_rules: got unstable=%0d overissue=%0d want 0 0", stall_viol, viol);
    end
  endtask

  task automatic test_zero_len;
    int rel;
    rdy = 1'b1;
    start_xfer('h123, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_len_done: got done=%b busy=%b want 1 0", done, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (en_cnt != 0 || vld_cnt != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL zero_len_quiet: got issues=%0d vld=%0d dones=%0d want 0 0 1", en_cnt, vld_cnt, done_cnt);
    end
    build_exp('h50, 4);
    start_xfer('h50, 4);
    start = 1'b1;
    base = 14'h90;
    len = 15'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, rel);
    total++;
    if (rel < 0 || diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL ignored_start_bytes: rel=%0d first diff %0d, got %0d bytes want %0d", rel, diff(got, exp_b), got.size(), exp_b.size());
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 1 || en_cnt != 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_start_extra: got dones=%0d issues=%0d busy=%b want 1 4 0", done_cnt, en_cnt, busy);
    end
  endtask

  task automatic test_back_to_back;
    int rel;
    rdy = 1'b1;
    build_exp('h100, 3);
    start_xfer('h100, 3);
    wait_done(0, rel);
    total++;
    if (rel < 0 || diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL b2b_first: rel=%0d first diff %0d, got %0d bytes want %0d", rel, diff(got, exp_b), got.size(), exp_b.size());
    end
    build_exp('h200, 3);
    start_xfer('h200, 3);
    wait_done(0, rel);
    total++;
    if (rel != 6 || first_iss != 1 || diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL b2b_second: got done=%0d issue=%0d diff=%0d want 6 1 -1", rel, first_iss, diff(got, exp_b));
    end
  endtask

  task automatic test_reset_mid;
    int rel;
    rdy = 1'b1;
    start_xfer('h20, 16);
    repeat (5) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || vld !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_active: got busy=%b vld=%b want 1 1", busy, vld);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, rom_en, rom_addr, vld, dat} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got busy=%b done=%b en=%b addr=%h vld=%b dat=%h, want all 0", busy, done, rom_en, rom_addr, vld, dat);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_nodone: got dones=%0d busy=%b want 0 0", done_cnt, busy);
    end
    build_exp('h40, 2);
    start_xfer('h40, 2);
    wait_done(0, rel);
    total++;
    if (rel < 0 || diff(got, exp_b) != -1) begin
      bad++;
      $display("FAIL reset_mid_restart: rel=%0d first diff %0d, got %0d bytes want %0d", rel, diff(got, exp_b), got.size(), exp_b.size());
    end
  endtask

  task automatic test_random;
    int rel, b, l;
    for (int n = 0; n < 8; n++) begin
      b = $urandom_range(0, (1 << AW) - 1);
      l = $urandom_range(1, 40);
      build_exp(b, l);
      start_xfer(b, l);
      wait_done(2, rel);
      total++;
      if (rel < 0 || diff(got, exp_b) != -1 || diff(iss, exp_a) != -1) begin
        bad++;
        $display("FAIL random_%0d_data: base=%h len=%0d rel=%0d byte diff %0d addr diff %0d, want -1 -1", n, b, l, rel, diff(got, exp_b), diff(iss, exp_a));
      end
      total++;
      if (stall_viol != 0 || viol != 0) begin
        bad++;
        $display("FAIL random_%0d_rules: got unstable=%0d overissue=%0d want 0 0", n, stall_viol, viol);
      end
`ifdef ROM_READER_CSUM_EN
      total++;
      if (csum !== DW'(exp_csum)) begin
        bad++;
        $display("FAIL random_%0d_csum: got %h want %h", n, csum, exp_csum);
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero_len;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
